// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the register/status hazard scoreboard.
// Condition code "always" and the register index type live here.
package hazard_scoreboard_pkg;

  localparam logic [3:0] COND_AL  = 4'b1110;
  localparam int         NUM_REGS = 16;
  localparam int         CNT_W    = 2;

  typedef logic [3:0] reg_idx_t;

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// Saturating up/down in-flight counter.
// Simultaneous inc and dec cancel; saturation raises a one-cycle flag.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         ovf_o,
  output logic         udf_o
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;

  // next count with hold-at-limit behaviour
  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    udf_o = 1'b0;
    unique case (1'b1)
      (inc_i & ~dec_i): begin
        if (cnt_q == MAX) ovf_o = 1'b1;
        else              cnt_d = cnt_q + W'(1);
      end
      (dec_i & ~inc_i): begin
        if (cnt_q == '0) udf_o = 1'b1;
        else             cnt_d = cnt_q - W'(1);
      end
      default: ;
    endcase
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register and status writers between ID and WB
// and raises a stall when the instruction in ID reads a busy value.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = hazard_scoreboard_pkg::NUM_REGS,
  parameter int CNT_W     = hazard_scoreboard_pkg::CNT_W,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic        issue_wb_en_i,
  input  reg_idx_t    issue_dest_i,
  input  logic        issue_s_i,
  input  reg_idx_t    src1_i,
  input  reg_idx_t    src2_i,
  input  logic        use_src1_i,
  input  logic        use_src2_i,
  input  logic [3:0]  cond_i,
  input  logic        wb_en_i,
  input  reg_idx_t    wb_dest_i,
  input  logic        status_wr_i,
  output logic        hazard_o,
  output logic        err_o,
  output logic [31:0] stall_cycles_o
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS:0]   ovf, udf;
  logic [CNT_W-1:0]    scnt;
  logic                s_busy;
  logic                err_q, err_d;
  logic [31:0]         stall_q, stall_d;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic [CNT_W-1:0] cnt;
    logic             inc, dec, wb_hit;

    assign wb_hit = wb_en_i & (wb_dest_i == reg_idx_t'(r));
    assign inc    = issue_valid_i & issue_wb_en_i
                  & (issue_dest_i == reg_idx_t'(r));
    assign dec    = wb_hit;

    sb_counter #(.W(CNT_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (inc),
      .dec_i   (dec),
      .count_o (cnt),
      .ovf_o   (ovf[r]),
      .udf_o   (udf[r])
    );

    // last writer retiring this cycle is forwarded, so not busy
    assign busy[r] = (cnt != '0)
                   & ~(WB_BYPASS & wb_hit & (cnt == CNT_W'(1)));
  end

  sb_counter #(.W(CNT_W)) u_scnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (issue_valid_i & issue_s_i),
    .dec_i   (status_wr_i),
    .count_o (scnt),
    .ovf_o   (ovf[NUM_REGS]),
    .udf_o   (udf[NUM_REGS])
  );

  // flags are pending unless the last setter writes them right now
  assign s_busy = (cond_i != COND_AL) & (scnt != '0)
                & ~(status_wr_i & (scnt == CNT_W'(1)));

  // stall decision from scoreboard state and ID sources only
  always_comb begin
    hazard_o = (use_src1_i & busy[src1_i])
             | (use_src2_i & busy[src2_i])
             | s_busy;
  end

  // sticky error and stall statistics next state
  always_comb begin
    err_d   = err_q | (|ovf) | (|udf);
    stall_d = stall_q + {31'd0, hazard_o};
  end

  // sticky error and stall counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign err_o          = err_q;
  assign stall_cycles_o = stall_q;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: NUM_REGS, default 16, number of architectural registers tracked.
REQ-002 Parameter: CNT_W, default 2, per-register in-flight counter width (max 3 writers in flight: EX, MEM, WB).
REQ-003 Parameter: WB_BYPASS, default 1, treat same-cycle final writeback as resolved.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 issue_valid  in  1  instruction leaves ID this cycle (not stalled, not flushed).
REQ-007 issue_wb_en  in  1  issued instruction writes a register (already condition-gated).
REQ-008 issue_dest  in  4  destination of issued instruction.
REQ-009 issue_s  in  1  issued instruction updates status register.
REQ-010 src1, src2  in  4 each  source registers of instruction in ID.
REQ-011 use_src1, use_src2  in  1 each  source actually read (src2 = Rd for stores).
REQ-012 cond  in  4  condition field of instruction in ID.
REQ-013 wb_en, wb_dest  in  1/4  writeback-stage register write.
REQ-014 status_wr  in  1  status register written in EX this cycle.
REQ-015 hazard  out  1  stall ID/IF; combinational from state and current inputs.
REQ-016 err  out  1  sticky counter overflow/underflow flag.
REQ-017 stall_cycles  out  32  count of cycles with hazard=1.

Function
REQ-018 Per register r: cnt[r] += 1 when issue_valid & issue_wb_en & issue_dest==r; cnt[r] -= 1 when wb_en & wb_dest==r; both in one cycle: unchanged.
REQ-019 Status counter scnt (CNT_W bits): +1 on issue_valid & issue_s, -1 on status_wr, both: unchanged.
REQ-020 Register busy(r) = cnt[r]!=0, except when WB_BYPASS=1 and wb_en & wb_dest==r & cnt[r]==1: not busy.
REQ-021 hazard = (use_src1 & busy(src1)) | (use_src2 & busy(src2)) | (cond!=4'b1110 & scnt!=0 & !(status_wr & scnt==1)).
REQ-022 hazard does not depend on issue_* inputs (no combinational loop through ID).
REQ-023 Increment at cnt==max: counter holds, err set. Decrement at 0: counter holds at 0, err set. Same for scnt.
REQ-024 err stays 1 until reset.
REQ-025 stall_cycles increments every cycle hazard=1, wraps 0xFFFFFFFF -> 0.
REQ-026 Branch flush only suppresses issue_valid; issued entries are never squashed.
REQ-027 No latency on outputs: counter updates visible to hazard the cycle after the edge.

Reset
REQ-028 On rst=1 at a clock edge: all cnt, scnt, stall_cycles = 0, err = 0; hazard then depends only on inputs with empty scoreboard (= 0).
REQ-029 rst mid-operation discards all in-flight tracking; the pipeline is reset with it.

Structure
REQ-030 Shared package holds COND_AL (4'b1110), NUM_REGS, CNT_W, and the register-index type.
REQ-031 One sub-module, sb_counter: saturating up/down counter with inc, dec, count, ovf, udf; instantiated NUM_REGS+1 times.

Verification
REQ-032 Issue ADD R3 (wb_en); next cycle src1=R3, use_src1=1 -> hazard=1 until wb_en,wb_dest=3 cycle; that cycle hazard=0 (WB_BYPASS=1), cnt[3]=0 after.
REQ-033 Issue two writers to R5 back-to-back, one wb to R5 -> hazard stays 1 for src R5; second wb -> hazard 0.
REQ-034 Issue CMP (issue_s=1); ID has cond=0000 -> hazard=1 until status_wr; ID with cond=1110 -> hazard=0 throughout.
REQ-035 Same cycle issue_dest=7 issue and wb_dest=7 with cnt[7]=1 -> cnt[7] stays 1, err=0.
REQ-036 wb_en to R9 with cnt[9]=0 -> err=1, cnt[9]=0; 4 issues to R2 without wb -> err=1, cnt[2]=3.
REQ-037 Hazard held 10 cycles then rst -> stall_cycles reads 10 before reset, 0 and err=0 after.
